// File: rtl/fighter_pkg.sv
// fighter_pkg: animation state encoding, screen size and default fighter timing constants.
package fighter_pkg;
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PUNCH    = 2'd1,
        ST_COOLDOWN = 2'd2
    } anim_state_t;
    localparam int SCREEN_W            = 640;
    localparam int SCREEN_H            = 480;
    localparam int DEF_HITBOX_W        = 80;
    localparam int DEF_HITBOX_H        = 160;
    localparam int DEF_IDLE_FRAMES     = 3;
    localparam int DEF_PUNCH_FRAMES    = 3;
    localparam int DEF_TICKS_PER_FRAME = 8;
    localparam int DEF_COOLDOWN_TICKS  = 16;
    localparam int CNT_W               = 8;
endpackage

// File: rtl/hitbox_mapper.sv
// hitbox_mapper: registers the current pixel as hitbox-relative coordinates.
// Bounds use 11-bit sums so a hitbox hanging off the right/bottom edge clips instead of wrapping.
module hitbox_mapper
    import fighter_pkg::*;
#(
    parameter int HITBOX_W = DEF_HITBOX_W,
    parameter int HITBOX_H = DEF_HITBOX_H
) (
    input  logic       vga_clk,
    input  logic       reset,
    input  logic [9:0] draw_x,
    input  logic [9:0] draw_y,
    input  logic [9:0] pos_x,
    input  logic [9:0] pos_y,
    output logic [9:0] rel_x,
    output logic [9:0] rel_y,
    output logic       in_hitbox
);
    logic [10:0] x_end, y_end;
    logic        hit;
    assign x_end = {1'b0, pos_x} + 11'(HITBOX_W);
    assign y_end = {1'b0, pos_y} + 11'(HITBOX_H);
    assign hit   = draw_x >= pos_x && {1'b0, draw_x} < x_end &&
                   draw_y >= pos_y && {1'b0, draw_y} < y_end;
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            rel_x     <= '0;
            rel_y     <= '0;
            in_hitbox <= 1'b0;
        end else begin
            rel_x     <= hit ? draw_x - pos_x : '0;
            rel_y     <= hit ? draw_y - pos_y : '0;
            in_hitbox <= hit;
        end
    end
endmodule

// File: rtl/fighter_anim_seq.sv
// fighter_anim_seq: per-fighter IDLE/PUNCH/COOLDOWN sequencer, frame-start position latch and hitbox mapping.
// Define FIGHTER_ANIM_PINGPONG_EN to ping-pong the idle frames instead of wrapping them.
module fighter_anim_seq
    import fighter_pkg::*;
#(
    parameter int HITBOX_W        = DEF_HITBOX_W,
    parameter int HITBOX_H        = DEF_HITBOX_H,
    parameter int IDLE_FRAMES     = DEF_IDLE_FRAMES,
    parameter int PUNCH_FRAMES    = DEF_PUNCH_FRAMES,
    parameter int TICKS_PER_FRAME = DEF_TICKS_PER_FRAME,
    parameter int COOLDOWN_TICKS  = DEF_COOLDOWN_TICKS
) (
    input  logic        vga_clk,
    input  logic        reset,
    input  logic        frame_tick,
    input  logic [9:0]  pos_x,
    input  logic [9:0]  pos_y,
    input  logic        facing_left,
    input  logic        punch_req,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    output logic [9:0]  rel_x,
    output logic [9:0]  rel_y,
    output logic        in_hitbox,
    output logic        mirror,
    output anim_state_t anim_state,
    output logic [1:0]  frame_idx,
    output logic        attack_active
);
    logic [9:0]       pos_x_l, pos_y_l;
    logic [CNT_W-1:0] tick_cnt, cd_cnt;
    logic             tick_wrap;
    logic [1:0]       idle_nx;
    assign tick_wrap = tick_cnt == CNT_W'(TICKS_PER_FRAME - 1);
`ifdef FIGHTER_ANIM_PINGPONG_EN
    logic dir_dn, dir_nx;
    always_comb begin
        dir_nx  = dir_dn ? frame_idx != 2'd0 : frame_idx == 2'(IDLE_FRAMES - 1);
        idle_nx = dir_nx ? frame_idx - 1'b1 : frame_idx + 1'b1;
    end
`else
    assign idle_nx = frame_idx == 2'(IDLE_FRAMES - 1) ? 2'd0 : frame_idx + 1'b1;
`endif
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            pos_x_l       <= '0;
            pos_y_l       <= '0;
            mirror        <= 1'b0;
            anim_state    <= ST_IDLE;
            frame_idx     <= '0;
            tick_cnt      <= '0;
            cd_cnt        <= '0;
            attack_active <= 1'b0;
`ifdef FIGHTER_ANIM_PINGPONG_EN
            dir_dn        <= 1'b0;
`endif
        end else if (frame_tick) begin
            pos_x_l       <= pos_x;
            pos_y_l       <= pos_y;
            mirror        <= facing_left;
            tick_cnt      <= tick_wrap ? '0 : tick_cnt + 1'b1;
            attack_active <= 1'b0;
            case (anim_state)
                ST_IDLE: begin
                    if (punch_req) begin
                        anim_state <= ST_PUNCH;
                        frame_idx  <= '0;
                        tick_cnt   <= '0;
                    end else if (tick_wrap) begin
                        frame_idx <= idle_nx;
`ifdef FIGHTER_ANIM_PINGPONG_EN
                        dir_dn    <= dir_nx;
`endif
                    end
                end
                ST_PUNCH: begin
                    if (!tick_wrap) begin
                        attack_active <= frame_idx == 2'd1;
                    end else if (frame_idx == 2'(PUNCH_FRAMES - 1)) begin
                        anim_state <= ST_COOLDOWN;
                        frame_idx  <= '0;
                        cd_cnt     <= CNT_W'(COOLDOWN_TICKS);
`ifdef FIGHTER_ANIM_PINGPONG_EN
                        dir_dn     <= 1'b0;
`endif
                    end else begin
                        frame_idx     <= frame_idx + 1'b1;
                        attack_active <= frame_idx == 2'd0;
                    end
                end
                ST_COOLDOWN: begin
                    cd_cnt <= cd_cnt - 1'b1;
                    if (tick_wrap) begin
                        frame_idx <= idle_nx;
`ifdef FIGHTER_ANIM_PINGPONG_EN
                        dir_dn    <= dir_nx;
`endif
                    end
                    if (cd_cnt == CNT_W'(1))
                        anim_state <= ST_IDLE;
                end
                default: anim_state <= ST_IDLE;
            endcase
        end
    end
    hitbox_mapper #(
        .HITBOX_W(HITBOX_W),
        .HITBOX_H(HITBOX_H)
    ) u_mapper (
        .vga_clk  (vga_clk),
        .reset    (reset),
        .draw_x   (DrawX),
        .draw_y   (DrawY),
        .pos_x    (pos_x_l),
        .pos_y    (pos_y_l),
        .rel_x    (rel_x),
        .rel_y    (rel_y),
        .in_hitbox(in_hitbox)
    );
endmodule

// File: tb/tb_fighter_anim_seq.sv
// tb_fighter_anim_seq: directed checks of animation sequencing, latching and hitbox mapping.
module tb_fighter_anim_seq;
    import fighter_pkg::*;
    logic        vga_clk = 1'b0;
    logic        reset = 1'b1, frame_tick = 1'b0, punch_req = 1'b0, facing_left = 1'b0;
    logic [9:0]  pos_x = '0, pos_y = '0, DrawX = '0, DrawY = '0;
    logic [9:0]  rel_x, rel_y;
    logic        in_hitbox, mirror, attack_active;
    anim_state_t anim_state;
    logic [1:0]  frame_idx;
    int vectors = 0, miscompares = 0;

    fighter_anim_seq dut (
        .vga_clk(vga_clk), .reset(reset), .frame_tick(frame_tick),
        .pos_x(pos_x), .pos_y(pos_y), .facing_left(facing_left), .punch_req(punch_req),
        .DrawX(DrawX), .DrawY(DrawY), .rel_x(rel_x), .rel_y(rel_y), .in_hitbox(in_hitbox),
        .mirror(mirror), .anim_state(anim_state), .frame_idx(frame_idx), .attack_active(attack_active)
    );

    always #5 vga_clk = ~vga_clk;

    task automatic do_reset();
        reset = 1'b1; frame_tick = 1'b0; punch_req = 1'b0;
        @(posedge vga_clk); #1;
        reset = 1'b0;
    endtask

    task automatic tick(input logic req);
        frame_tick = 1'b1; punch_req = req;
        @(posedge vga_clk); #1;
        frame_tick = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if ({anim_state, frame_idx, attack_active, mirror, in_hitbox, rel_x, rel_y} !== '0) begin
            miscompares++;
            $display("FAIL reset_state: got state=%0d frame=%0d att=%0d mir=%0d in=%0d rx=%0d ry=%0d, expected all 0",
                     anim_state, frame_idx, attack_active, mirror, in_hitbox, rel_x, rel_y);
        end
    endtask

    task automatic test_idle();
        logic [1:0] seq [4];
`ifdef FIGHTER_ANIM_PINGPONG_EN
        seq = '{2'd0, 2'd1, 2'd2, 2'd1};
`else
        seq = '{2'd0, 2'd1, 2'd2, 2'd0};
`endif
        do_reset();
        for (int k = 1; k <= 48; k++) begin
            logic [1:0] ef;
`ifdef FIGHTER_ANIM_PINGPONG_EN
            ef = seq[(k / 8) % 4];
`else
            ef = seq[(k / 8) % 3];
`endif
            tick(1'b0);
            vectors++;
            if (anim_state !== ST_IDLE || frame_idx !== ef || attack_active !== 1'b0) begin
                miscompares++;
                $display("FAIL idle_tick%0d: got state=%0d frame=%0d att=%0d, expected state=0 frame=%0d att=0",
                         k, anim_state, frame_idx, attack_active, ef);
            end
        end
    endtask

    task automatic run_punch(input logic hold);
        do_reset();
        for (int k = 0; k < 3; k++) tick(1'b0);
        tick(1'b1);
        vectors++;
        if (anim_state !== ST_PUNCH || frame_idx !== 2'd0 || attack_active !== 1'b0) begin
            miscompares++;
            $display("FAIL punch_start: got state=%0d frame=%0d att=%0d, expected state=1 frame=0 att=0",
                     anim_state, frame_idx, attack_active);
        end
        for (int j = 1; j <= 24; j++) begin
            anim_state_t es;
            logic [1:0]  ef;
            logic        ea;
            es = j == 24 ? ST_COOLDOWN : ST_PUNCH;
            ef = j == 24 ? 2'd0 : 2'(j / 8);
            ea = j >= 8 && j < 16;
            tick(hold);
            vectors++;
            if (anim_state !== es || frame_idx !== ef || attack_active !== ea) begin
                miscompares++;
                $display("FAIL punch_tick%0d: got state=%0d frame=%0d att=%0d, expected state=%0d frame=%0d att=%0d",
                         j, anim_state, frame_idx, attack_active, es, ef, ea);
            end
        end
        for (int j = 1; j <= 16; j++) begin
            anim_state_t es;
            es = j == 16 ? ST_IDLE : ST_COOLDOWN;
            tick(hold);
            vectors++;
            if (anim_state !== es || frame_idx !== 2'(j / 8) || attack_active !== 1'b0) begin
                miscompares++;
                $display("FAIL cooldown_tick%0d: got state=%0d frame=%0d att=%0d, expected state=%0d frame=%0d att=0",
                         j, anim_state, frame_idx, attack_active, es, j / 8);
            end
        end
        if (!hold) begin
            tick(1'b0);
            vectors++;
            if (anim_state !== ST_IDLE || frame_idx !== 2'd2) begin
                miscompares++;
                $display("FAIL idle_after_cd: got state=%0d frame=%0d, expected state=0 frame=2", anim_state, frame_idx);
            end
        end
        tick(1'b1);
        vectors++;
        if (anim_state !== ST_PUNCH || frame_idx !== 2'd0) begin
            miscompares++;
            $display("FAIL repunch: got state=%0d frame=%0d, expected state=1 frame=0", anim_state, frame_idx);
        end
    endtask

    task automatic test_punch();
        run_punch(1'b0);
    endtask

    task automatic test_no_retrigger();
        run_punch(1'b1);
    endtask

    task automatic test_hitbox();
        int xs [10] = '{0, 100, 599, 600, 601, 639, 639, 620, 620, 610};
        int ys [10] = '{0, 450, 450, 450, 400, 479, 399, 300, 479, 420};
        do_reset();
        pos_x = 10'd600; pos_y = 10'd400; facing_left = 1'b0;
        tick(1'b0);
        for (int i = 0; i < 10; i++) begin
            logic       ei;
            logic [9:0] ex, ey;
            DrawX = 10'(xs[i]); DrawY = 10'(ys[i]);
            ei = xs[i] >= 600 && xs[i] < 680 && ys[i] >= 400 && ys[i] < 560;
            ex = ei ? 10'(xs[i] - 600) : 10'd0;
            ey = ei ? 10'(ys[i] - 400) : 10'd0;
            @(posedge vga_clk); #1;
            vectors++;
            if (in_hitbox !== ei || rel_x !== ex || rel_y !== ey) begin
                miscompares++;
                $display("FAIL hitbox(%0d,%0d): got in=%0d rx=%0d ry=%0d, expected in=%0d rx=%0d ry=%0d",
                         xs[i], ys[i], in_hitbox, rel_x, rel_y, ei, ex, ey);
            end
        end
        DrawX = 10'd0; DrawY = 10'd0;
        #1;
        vectors++;
        if (in_hitbox !== 1'b1 || rel_x !== 10'd10 || rel_y !== 10'd20) begin
            miscompares++;
            $display("FAIL hitbox_latency: got in=%0d rx=%0d ry=%0d before edge, expected in=1 rx=10 ry=20",
                     in_hitbox, rel_x, rel_y);
        end
    endtask

    task automatic test_latch();
        DrawX = 10'd620; DrawY = 10'd420;
        pos_x = 10'd100; facing_left = 1'b1;
        @(posedge vga_clk); #1;
        vectors++;
        if (rel_x !== 10'd20 || mirror !== 1'b0) begin
            miscompares++;
            $display("FAIL latch_hold: got rx=%0d mir=%0d, expected rx=20 mir=0", rel_x, mirror);
        end
        tick(1'b0);
        vectors++;
        if (mirror !== 1'b1) begin
            miscompares++;
            $display("FAIL latch_mirror: got mir=%0d, expected 1", mirror);
        end
        DrawX = 10'd150;
        @(posedge vga_clk); #1;
        vectors++;
        if (in_hitbox !== 1'b1 || rel_x !== 10'd50 || rel_y !== 10'd20) begin
            miscompares++;
            $display("FAIL latch_newpos: got in=%0d rx=%0d ry=%0d, expected in=1 rx=50 ry=20", in_hitbox, rel_x, rel_y);
        end
    endtask

    task automatic test_reset_mid_punch();
        pos_x = 10'd100; pos_y = 10'd400; facing_left = 1'b1;
        DrawX = 10'd150; DrawY = 10'd420;
        do_reset();
        tick(1'b1);
        for (int k = 0; k < 8; k++) tick(1'b0);
        vectors++;
        if (anim_state !== ST_PUNCH || attack_active !== 1'b1 || mirror !== 1'b1 || rel_x !== 10'd50) begin
            miscompares++;
            $display("FAIL pre_reset: got state=%0d att=%0d mir=%0d rx=%0d, expected state=1 att=1 mir=1 rx=50",
                     anim_state, attack_active, mirror, rel_x);
        end
        reset = 1'b1; frame_tick = 1'b1;
        #1;
        vectors++;
        if ({anim_state, frame_idx, attack_active, mirror, in_hitbox, rel_x, rel_y} !== '0) begin
            miscompares++;
            $display("FAIL async_reset: got state=%0d frame=%0d att=%0d mir=%0d in=%0d rx=%0d ry=%0d, expected all 0",
                     anim_state, frame_idx, attack_active, mirror, in_hitbox, rel_x, rel_y);
        end
        @(posedge vga_clk); #1;
        vectors++;
        if (anim_state !== ST_IDLE || mirror !== 1'b0 || attack_active !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_over_tick: got state=%0d mir=%0d att=%0d, expected 0 0 0", anim_state, mirror, attack_active);
        end
        reset = 1'b0; frame_tick = 1'b0;
        DrawX = 10'd50; DrawY = 10'd50;
        @(posedge vga_clk); #1;
        vectors++;
        if (in_hitbox !== 1'b1 || rel_x !== 10'd50 || rel_y !== 10'd50) begin
            miscompares++;
            $display("FAIL latch_cleared: got in=%0d rx=%0d ry=%0d, expected in=1 rx=50 ry=50", in_hitbox, rel_x, rel_y);
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_punch();
        test_no_retrigger();
        test_hitbox();
        test_latch();
        test_reset_mid_punch();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
